// File: rtl/rf_scrubber.sv
// rf_scrubber: background ECC scrub of x1..x31 through shared read port 1.
// Optional feature macro RF_SCRUB_STATS_EN adds saturating ce/uce counters.
module rf_scrubber #(
  parameter int PERIOD = 64,
  parameter int CNT_W  = 16
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_enable_i,
  input  logic        s_op_rs1_used_i,
  output logic        s_rf_rd_grant_o,
  output logic [4:0]  s_rf_rd_add_o,
  input  logic [31:0] s_rf_rd_val_i,
  input  logic        s_rf_ce_i,
  input  logic        s_rf_uce_i,
  input  logic        s_wb_we_i,
  input  logic [4:0]  s_wb_rd_i,
  output logic        s_scrub_we_o,
  output logic [4:0]  s_scrub_add_o,
  output logic [31:0] s_scrub_val_o,
  output logic        s_uce_o,
  output logic [4:0]  s_uce_add_o
`ifdef RF_SCRUB_STATS_EN
  ,
  output logic [CNT_W-1:0] s_ce_cnt_o,
  output logic [CNT_W-1:0] s_uce_cnt_o
`endif
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  // Illegal configurations stop elaboration instead of building a broken scrubber.
  if (PERIOD < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("rf_scrubber: PERIOD and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    S_WAIT,
    S_READ,
    S_WRITE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    addr_q;
  logic [4:0]    addr_d;
  logic [31:0]   data_q;
  logic          uce_q;
  logic [4:0]    uce_add_q;
  logic          wb_hit;

`ifdef RF_SCRUB_STATS_EN
  logic [CNT_W-1:0] ce_cnt_q;
  logic [CNT_W-1:0] uce_cnt_q;

  assign s_ce_cnt_o  = ce_cnt_q;
  assign s_uce_cnt_o = uce_cnt_q;
`endif

  // Next scrub target: x1..x31, x0 is skipped on wrap.
  assign addr_d = (addr_q == 5'd31) ? 5'd1 : addr_q + 5'd1;
  assign wb_hit = s_wb_we_i && (s_wb_rd_i == addr_q);

  // Port ownership drops in the same cycle as enable or contention.
  assign s_rf_rd_grant_o = (state_q == S_READ) && s_enable_i
                           && !s_op_rs1_used_i;
  assign s_rf_rd_add_o   = s_rf_rd_grant_o ? addr_q : 5'd0;
  assign s_scrub_we_o    = (state_q == S_WRITE) && s_enable_i
                           && !s_wb_we_i;
  assign s_scrub_add_o   = s_scrub_we_o ? addr_q : 5'd0;
  assign s_scrub_val_o   = s_scrub_we_o ? data_q : 32'd0;
  assign s_uce_o         = uce_q;
  assign s_uce_add_o     = uce_add_q;

  // Scrub FSM: idle PERIOD cycles, read when the pipeline allows, repair.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      addr_q    <= 5'd1;
      data_q    <= '0;
      uce_q     <= 1'b0;
      uce_add_q <= '0;
`ifdef RF_SCRUB_STATS_EN
      ce_cnt_q  <= '0;
      uce_cnt_q <= '0;
`endif
    end else begin
      uce_q <= 1'b0;
      if (!s_enable_i) begin
        state_q <= S_WAIT;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_READ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_READ: begin
            if (!s_op_rs1_used_i) begin
              if (wb_hit) begin
                addr_q  <= addr_d;
                state_q <= S_WAIT;
              end else if (s_rf_uce_i) begin
                uce_q     <= 1'b1;
                uce_add_q <= addr_q;
                addr_q    <= addr_d;
                state_q   <= S_WAIT;
`ifdef RF_SCRUB_STATS_EN
                if (~&uce_cnt_q) uce_cnt_q <= uce_cnt_q + 1'b1;
`endif
              end else if (s_rf_ce_i) begin
                data_q  <= s_rf_rd_val_i;
                state_q <= S_WRITE;
              end else begin
                addr_q  <= addr_d;
                state_q <= S_WAIT;
              end
            end
          end
          S_WRITE: begin
            if (wb_hit) begin
              addr_q  <= addr_d;
              state_q <= S_WAIT;
            end else if (!s_wb_we_i) begin
              addr_q  <= addr_d;
              state_q <= S_WAIT;
`ifdef RF_SCRUB_STATS_EN
              if (~&ce_cnt_q) ce_cnt_q <= ce_cnt_q + 1'b1;
`endif
            end
          end
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_scrubber.sv
// tb_rf_scrubber: randomized and directed checks of rf_scrubber
// against a transaction-level model of the scrub schedule.
module tb_rf_scrubber;
  localparam int P    = 4;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en, op, wbwe, ce, uce;
  logic [4:0]  wbrd;
  logic [31:0] rdval;
  logic grant, we, uce_o;
  logic [4:0]  rd_add, sc_add, uce_add;
  logic [31:0] sc_val;
`ifdef RF_SCRUB_STATS_EN
  logic [CW-1:0] ce_cnt, uce_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // model: idle cycles since last finished transaction, target, pending repair
  int          m_idle, m_addr, m_uce_add, m_ce_cnt, m_uce_cnt;
  bit          m_pend, m_uce, e_grant, e_we;
  logic [31:0] m_val;

  always #5 clk = ~clk;

  rf_scrubber #(.PERIOD(P), .CNT_W(CW)) dut (
    .s_clk_i         (clk),
    .s_resetn_i      (rst_n),
    .s_enable_i      (en),
    .s_op_rs1_used_i (op),
    .s_rf_rd_grant_o (grant),
    .s_rf_rd_add_o   (rd_add),
    .s_rf_rd_val_i   (rdval),
    .s_rf_ce_i       (ce),
    .s_rf_uce_i      (uce),
    .s_wb_we_i       (wbwe),
    .s_wb_rd_i       (wbrd),
    .s_scrub_we_o    (we),
    .s_scrub_add_o   (sc_add),
    .s_scrub_val_o   (sc_val),
    .s_uce_o         (uce_o),
    .s_uce_add_o     (uce_add)
`ifdef RF_SCRUB_STATS_EN
    ,
    .s_ce_cnt_o      (ce_cnt),
    .s_uce_cnt_o     (uce_cnt)
`endif
  );

  function automatic void m_reset();
    m_idle = 0; m_addr = 1; m_pend = 0; m_val = '0;
    m_uce = 0; m_uce_add = 0; m_ce_cnt = 0; m_uce_cnt = 0;
  endfunction

  function automatic void m_eval();
    bit due;
    due     = en && !m_pend && (m_idle >= P);
    e_grant = due && !op;
    e_we    = en && m_pend && !wbwe;
  endfunction

  function automatic void m_done();
    m_addr = (m_addr == 31) ? 1 : m_addr + 1;
    m_idle = 0;
  endfunction

  function automatic void m_next();
    bit hit;
    bit nu;
    hit = wbwe && (int'(wbrd) == m_addr);
    nu  = 0;
    if (!en) begin
      m_idle = 0;
      m_pend = 0;
    end else if (e_grant) begin
      if (hit) m_done();
      else if (uce) begin
        nu = 1; m_uce_add = m_addr;
        if (m_uce_cnt < CMAX) m_uce_cnt++;
        m_done();
      end else if (ce) begin
        m_pend = 1; m_val = rdval;
      end else m_done();
    end else if (m_pend) begin
      if (hit) begin
        m_pend = 0; m_done();
      end else if (!wbwe) begin
        m_pend = 0;
        if (m_ce_cnt < CMAX) m_ce_cnt++;
        m_done();
      end
    end else if (m_idle < P) m_idle++;
    m_uce = nu;
  endfunction

  task automatic drive_clean();
    en = 1; op = 0; wbwe = 0; wbrd = 0; ce = 0; uce = 0; rdval = 0;
  endtask

  task automatic tick();
    m_eval();
    @(posedge clk);
    m_next();
    #1;
  endtask

  // run clean cycles until the model says a read of x<a> (0: any) is due
  task automatic advance_to(input int a);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      drive_clean();
      if (!m_pend && m_idle >= P && (a == 0 || m_addr == a)) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL advance_to got=timeout exp=read_of_x%0d", a);
    end
  endtask

  task automatic wait_grant(output int n, output bit ok);
    ok = 0; n = 0;
    for (int i = 0; i < 400; i++) begin
      drive_clean();
      #1;
      if (grant === 1'b1) begin
        ok = 1; n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%0b exp=0", grant); end
    checks++; if (rd_add !== 5'd0) begin failures++; $display("FAIL reset_rd_add got=%0d exp=0", rd_add); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we); end
    checks++; if (sc_add !== 5'd0) begin failures++; $display("FAIL reset_sc_add got=%0d exp=0", sc_add); end
    checks++; if (sc_val !== 32'd0) begin failures++; $display("FAIL reset_sc_val got=%h exp=0", sc_val); end
    checks++; if (uce_o !== 1'b0) begin failures++; $display("FAIL reset_uce got=%0b exp=0", uce_o); end
    checks++; if (uce_add !== 5'd0) begin failures++; $display("FAIL reset_uce_add got=%0d exp=0", uce_add); end
`ifdef RF_SCRUB_STATS_EN
    checks++; if (ce_cnt !== '0) begin failures++; $display("FAIL reset_ce_cnt got=%0d exp=0", ce_cnt); end
    checks++; if (uce_cnt !== '0) begin failures++; $display("FAIL reset_uce_cnt got=%0d exp=0", uce_cnt); end
`endif
  endtask

  task automatic test_clean_scan();
    int ga[$];
    int gc[$];
    for (int i = 0; i < 32 * (P + 1); i++) begin
      drive_clean();
      #1;
      m_eval();
      checks++;
      if (grant !== e_grant) begin
        failures++;
        $display("FAIL scan_grant cyc=%0d got=%0b exp=%0b", i, grant, e_grant);
      end
      if (grant === 1'b1) begin
        ga.push_back(int'(rd_add));
        gc.push_back(i);
      end
      tick();
    end
    checks++;
    if (ga.size() != 32) begin
      failures++;
      $display("FAIL scan_count got=%0d exp=32", ga.size());
    end
    for (int k = 0; k < ga.size() && k < 32; k++) begin
      checks++;
      if (ga[k] != (k % 31) + 1 || gc[k] != k * (P + 1) + P) begin
        failures++;
        $display("FAIL scan_seq k=%0d got=x%0d@%0d exp=x%0d@%0d",
                 k, ga[k], gc[k], (k % 31) + 1, k * (P + 1) + P);
      end
    end
  endtask

  task automatic test_stall();
    int a;
    advance_to(0);
    a  = m_addr;
    op = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (grant !== 1'b0 || rd_add !== 5'd0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%0b/%0d exp=0/0", i, grant, rd_add);
      end
      tick();
    end
    op = 0;
    #1;
    checks++;
    if (grant !== 1'b1 || rd_add !== 5'(a)) begin
      failures++;
      $display("FAIL stall_release got=%0b/%0d exp=1/%0d", grant, rd_add, a);
    end
    tick();
  endtask

  task automatic test_ce_write();
    advance_to(5);
    ce = 1; rdval = 32'hDEADBEEF;
    #1;
    checks++;
    if (grant !== 1'b1 || rd_add !== 5'd5) begin
      failures++;
      $display("FAIL cew_read got=%0b/%0d exp=1/5", grant, rd_add);
    end
    tick();
    ce = 0; rdval = 0; wbwe = 1; wbrd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (we !== 1'b0) begin failures++; $display("FAIL cew_blocked cyc=%0d got=%0b exp=0", i, we); end
      tick();
    end
    wbwe = 0;
    #1;
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL cew_we got=%0b exp=1", we); end
    checks++; if (sc_add !== 5'd5) begin failures++; $display("FAIL cew_add got=%0d exp=5", sc_add); end
    checks++; if (sc_val !== 32'hDEADBEEF) begin failures++; $display("FAIL cew_val got=%h exp=deadbeef", sc_val); end
    tick();
  endtask

  task automatic test_abort();
    int  n;
    bit  ok;
    advance_to(7);
    ce = 1; rdval = $urandom;
    tick();
    ce = 0; wbwe = 1; wbrd = 5'd7;
    #1;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL abort_we got=%0b exp=0", we); end
    tick();
    wait_grant(n, ok);
    checks++;
    if (!ok || n != P || rd_add !== 5'd8) begin
      failures++;
      $display("FAIL abort_next got=ok%0b/n%0d/x%0d exp=ok1/n%0d/x8", ok, n, rd_add, P);
    end
    tick();
  endtask

  task automatic test_uce();
    advance_to(12);
    uce = 1; ce = 1; rdval = $urandom;
    #1;
    checks++; if (grant !== 1'b1) begin failures++; $display("FAIL uce_read got=%0b exp=1", grant); end
    tick();
    drive_clean();
    #1;
    checks++; if (uce_o !== 1'b1) begin failures++; $display("FAIL uce_pulse got=%0b exp=1", uce_o); end
    checks++; if (uce_add !== 5'd12) begin failures++; $display("FAIL uce_add got=%0d exp=12", uce_add); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL uce_no_write got=%0b exp=0", we); end
`ifdef RF_SCRUB_STATS_EN
    checks++; if (uce_cnt !== 16'd1) begin failures++; $display("FAIL uce_cnt got=%0d exp=1", uce_cnt); end
    checks++; if (ce_cnt !== 16'd1) begin failures++; $display("FAIL ce_cnt got=%0d exp=1", ce_cnt); end
`endif
    tick();
    #1;
    checks++; if (uce_o !== 1'b0) begin failures++; $display("FAIL uce_single got=%0b exp=0", uce_o); end
    checks++; if (uce_add !== 5'd12) begin failures++; $display("FAIL uce_add_held got=%0d exp=12", uce_add); end
  endtask

  task automatic test_enable();
    int a, n;
    bit ok;
    advance_to(0);
    a  = m_addr;
    en = 0;
    #1;
    checks++;
    if (grant !== 1'b0 || rd_add !== 5'd0) begin
      failures++;
      $display("FAIL en_read_drop got=%0b/%0d exp=0/0", grant, rd_add);
    end
    tick();
    wait_grant(n, ok);
    checks++;
    if (!ok || n != P || rd_add !== 5'(a)) begin
      failures++;
      $display("FAIL en_resume got=ok%0b/n%0d/x%0d exp=ok1/n%0d/x%0d", ok, n, rd_add, P, a);
    end
    ce = 1; rdval = $urandom;
    tick();
    drive_clean();
    #1;
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL en_write got=%0b exp=1", we); end
    en = 0;
    #1;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL en_write_drop got=%0b exp=0", we); end
    tick();
    wait_grant(n, ok);
    checks++;
    if (!ok || n != P || rd_add !== 5'(a)) begin
      failures++;
      $display("FAIL en_retain got=ok%0b/n%0d/x%0d exp=ok1/n%0d/x%0d", ok, n, rd_add, P, a);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 19) != 0);
      op    = ($urandom_range(0, 3) == 0);
      wbwe  = ($urandom_range(0, 2) == 0);
      wbrd  = $urandom_range(0, 1) ? 5'(m_addr) : 5'($urandom_range(0, 31));
      ce    = ($urandom_range(0, 2) == 0);
      uce   = ($urandom_range(0, 9) == 0);
      rdval = $urandom;
      #1;
      m_eval();
      checks++;
      if (grant !== e_grant || rd_add !== (e_grant ? 5'(m_addr) : 5'd0)) begin
        failures++;
        $display("FAIL rnd_read cyc=%0d got=%0b/%0d exp=%0b/%0d", i, grant, rd_add, e_grant, e_grant ? m_addr : 0);
      end
      checks++;
      if (we !== e_we) begin
        failures++;
        $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", i, we, e_we);
      end
      if (e_we) begin
        checks++;
        if (sc_add !== 5'(m_addr) || sc_val !== m_val) begin
          failures++;
          $display("FAIL rnd_wdata cyc=%0d got=%0d/%h exp=%0d/%h", i, sc_add, sc_val, m_addr, m_val);
        end
      end
      checks++;
      if (uce_o !== m_uce || uce_add !== 5'(m_uce_add)) begin
        failures++;
        $display("FAIL rnd_uce cyc=%0d got=%0b/%0d exp=%0b/%0d", i, uce_o, uce_add, m_uce, m_uce_add);
      end
`ifdef RF_SCRUB_STATS_EN
      checks++;
      if (ce_cnt !== CW'(m_ce_cnt) || uce_cnt !== CW'(m_uce_cnt)) begin
        failures++;
        $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, ce_cnt, uce_cnt, m_ce_cnt, m_uce_cnt);
      end
`endif
      tick();
    end
  endtask

  task automatic test_reset_write();
    int n;
    bit ok;
    advance_to(0);
    ce = 1; rdval = $urandom;
    tick();
    drive_clean();
    #1;
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL rstw_we got=%0b exp=1", we); end
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (we !== 1'b0 || grant !== 1'b0 || uce_o !== 1'b0) begin
      failures++;
      $display("FAIL rstw_drop got=%0b/%0b/%0b exp=0/0/0", we, grant, uce_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
    wait_grant(n, ok);
    checks++;
    if (!ok || n != P || rd_add !== 5'd1) begin
      failures++;
      $display("FAIL rstw_restart got=ok%0b/n%0d/x%0d exp=ok1/n%0d/x1", ok, n, rd_add, P);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_clean();
    m_reset();
    #1;
    rst_n = 0;
    #2;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
    test_clean_scan();
    test_stall();
    test_ce_write();
    test_abort();
    test_uce();
    test_enable();
    test_random();
    test_reset_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_scrubber.md
Name: rf_scrubber

Overview:
- Background scrubber for the ECC-protected register file.
- Shares read port 1 with the OP stage; the pipeline always has priority.
- Walks x1..x31, reads each register, and writes back the decoder-corrected value when a correctable error is found.
- Reports uncorrectable errors. Sits beside the OP stage and in front of the register-file write-port mux.

Parameters:
PERIOD, 64, idle cycles in WAIT between consecutive scrub reads (>=1)
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  asynchronous active-low reset
s_enable_i  in  1  scrubbing enabled
s_op_rs1_used_i  in  1  OP stage uses read port 1 this cycle
s_rf_rd_grant_o  out  1  scrubber owns read port 1 this cycle (port-mux select)
s_rf_rd_add_o  out  5  read address while granted, else 0
s_rf_rd_val_i  in  32  decoder-corrected read data, same cycle as address
s_rf_ce_i  in  1  correctable error on read port 1
s_rf_uce_i  in  1  uncorrectable error on read port 1
s_wb_we_i  in  1  WB stage writes the register file this cycle
s_wb_rd_i  in  5  WB destination address
s_scrub_we_o  out  1  scrubber write request (write port free)
s_scrub_add_o  out  5  scrub write address
s_scrub_val_o  out  32  scrub write data
s_uce_o  out  1  one-cycle pulse: uncorrectable error found
s_uce_add_o  out  5  address of last uncorrectable error (held)

Behaviour:
- Clock/reset: single clock s_clk_i; reset s_resetn_i is asynchronous, active-low.
- Reset values: state WAIT, wait counter 0, scrub address 1, data register 0.
- Reset values (outputs): all outputs 0; s_uce_add_o 0.
- FSM states: WAIT, READ, WRITE.
- WAIT: counter increments each cycle while s_enable_i=1. At PERIOD-1, go to READ and clear the counter.
- READ: s_rf_rd_grant_o = !s_op_rs1_used_i (combinational). s_rf_rd_add_o = scrub address while granted.
- READ, not granted: stay in READ.
- READ, granted, read-write collision: if s_wb_we_i=1 and s_wb_rd_i equals the scrub address, the sample is discarded as clean. Advance the address and go to WAIT.
- READ, granted, s_rf_ce_i=1: latch s_rf_rd_val_i and go to WRITE.
- READ, granted, s_rf_uce_i=1 (ce=0): pulse s_uce_o next cycle, latch the address into s_uce_add_o, advance, go to WAIT.
- READ, granted, otherwise: advance and go to WAIT.
- WRITE: s_scrub_we_o = !s_wb_we_i (combinational); address and data come from the latched registers.
- WRITE completes on the first cycle with s_wb_we_i=0, then advances and goes to WAIT.
- WRITE abort: if WB writes the scrub address while in WRITE, the newer value supersedes; no scrub write, advance, go to WAIT.
- Address wrap: address advances 1..31, then wraps to 1. x0 is never scrubbed.
- s_enable_i=0: forces WAIT on the next edge and clears the counter. The address is retained. Grant and we drop combinationally in the same cycle.
- Pulse rules: s_uce_o is a single pulse and is never asserted during reset. ce and uce both high is treated as uce.
- Latency: a clean scan of all 31 registers with no pipeline contention takes 31*(PERIOD+1) cycles.

Optional Feature:
RF_SCRUB_STATS_EN:
- Defined: adds outputs s_ce_cnt_o and s_uce_cnt_o (CNT_W each). They count completed corrections and detected uncorrectable errors respectively.
- Counter behaviour: saturating at all-ones, reset to 0. Aborted writes are not counted.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- PERIOD=4, enable, no contention, clean RF -> grant pulses every 5 cycles, addresses 1,2,...,31,1; never address 0.
- s_op_rs1_used_i held 1 for 10 cycles during READ -> grant stays 0, address held; grant asserts the cycle after release.
- Read of x5 with ce=1, val=0xDEADBEEF, s_wb_we_i=1 for 3 cycles -> s_scrub_we_o=1 on the 4th cycle with add=5, val=0xDEADBEEF.
- In WRITE for x7, WB writes rd=7 -> no scrub write, next READ targets x8.
- uce=1 on x12 -> s_uce_o pulses once, s_uce_add_o=12; with RF_SCRUB_STATS_EN, s_uce_cnt_o=1.
- Async reset asserted during WRITE -> s_scrub_we_o drops immediately; after release, the scan restarts at x1 after PERIOD cycles.
